// File: rtl/pwm_ramp_ctrl.sv
// APB-programmable PWM sequencer: shadows period/compare, applies them only at
// period boundaries, and optionally ramps compare toward the target each period.
module pwm_ramp_ctrl #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    input  logic          period_wrap,
    output logic          pwm_en,
    output logic [DW-1:0] cfg_period,
    output logic [DW-1:0] cfg_cmpr,
    output logic          cfg_load,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, START, RUN, RAMP} state_t;

    localparam logic [AW-1:0] A_CTRL   = AW'(0);
    localparam logic [AW-1:0] A_PERIOD = AW'(1);
    localparam logic [AW-1:0] A_TARGET = AW'(2);
    localparam logic [AW-1:0] A_STEP   = AW'(3);
    localparam logic [AW-1:0] A_STATUS = AW'(4);
    localparam logic [AW-1:0] A_CMPR   = AW'(5);

    state_t        state_q, state_d;
    logic          en_q, en_d, ramp_en_q, ramp_en_d, pending_q, pending_d;
    logic [DW-1:0] period_sh_q, period_sh_d, target_sh_q, target_sh_d, step_q, step_d;
    logic [DW-1:0] cfg_period_q, cfg_period_d, cfg_cmpr_q, cfg_cmpr_d;
    logic          cfg_load_q, cfg_load_d, pwm_en_q, pwm_en_d, busy_q, busy_d;

    logic          wr, rd, pend_set, pend_clr;
    logic [DW-1:0] eff_tgt, eff_step, ramp_nxt;

    assign wr       = psel & penable & pwrite;
    assign rd       = psel & penable & ~pwrite;
    assign pready   = 1'b1;
    assign pslverr  = psel & penable & (paddr > A_CMPR);
    assign pend_set = wr & ((paddr == A_PERIOD) | (paddr == A_TARGET));

    assign eff_tgt  = (target_sh_q > period_sh_q) ? period_sh_q : target_sh_q;
    assign eff_step = (step_q == '0) ? DW'(1) : step_q;

    // Compare differences before stepping so neither direction can wrap.
    always_comb begin
        ramp_nxt = eff_tgt;
        if (cfg_cmpr_q < eff_tgt) begin
            if ((eff_tgt - cfg_cmpr_q) > eff_step) ramp_nxt = cfg_cmpr_q + eff_step;
        end else if (cfg_cmpr_q > eff_tgt) begin
            if ((cfg_cmpr_q - eff_tgt) > eff_step) ramp_nxt = cfg_cmpr_q - eff_step;
        end
    end

    always_comb begin
        prdata = '0;
        if (rd) begin
            case (paddr)
                A_CTRL:   prdata = {{(DW-2){1'b0}}, ramp_en_q, en_q};
                A_PERIOD: prdata = period_sh_q;
                A_TARGET: prdata = target_sh_q;
                A_STEP:   prdata = step_q;
                A_STATUS: prdata = {{(DW-3){1'b0}}, state_q == RUN, pending_q, busy_q};
                A_CMPR:   prdata = cfg_cmpr_q;
                default:  prdata = '0;
            endcase
        end
    end

    always_comb begin
        en_d         = en_q;
        ramp_en_d    = ramp_en_q;
        period_sh_d  = period_sh_q;
        target_sh_d  = target_sh_q;
        step_d       = step_q;
        state_d      = state_q;
        cfg_period_d = cfg_period_q;
        cfg_cmpr_d   = cfg_cmpr_q;
        cfg_load_d   = 1'b0;
        pwm_en_d     = pwm_en_q;
        pend_clr     = 1'b0;

        if (wr) begin
            case (paddr)
                A_CTRL:   begin en_d = pwdata[0]; ramp_en_d = pwdata[1]; end
                A_PERIOD: period_sh_d = pwdata;
                A_TARGET: target_sh_d = pwdata;
                A_STEP:   step_d      = pwdata;
                default:  ;
            endcase
        end

        if (!en_q) begin
            if (state_q != IDLE) begin
                state_d    = IDLE;
                pwm_en_d   = 1'b0;
                cfg_cmpr_d = '0;
                cfg_load_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = START;
                    cfg_period_d = period_sh_q;
                    cfg_cmpr_d   = ramp_en_q ? '0 : eff_tgt;
                    cfg_load_d   = 1'b1;
                    pwm_en_d     = 1'b1;
                    pend_clr     = 1'b1;
                end
                START: state_d = (ramp_en_q && eff_tgt != '0) ? RAMP : RUN;
                RUN: begin
                    if (period_wrap && pending_q) begin
                        cfg_period_d = period_sh_q;
                        cfg_load_d   = 1'b1;
                        pend_clr     = 1'b1;
                        if (ramp_en_q) state_d = RAMP;
                        else           cfg_cmpr_d = eff_tgt;
                    end
                end
                RAMP: begin
                    if (period_wrap) begin
                        cfg_cmpr_d = ramp_nxt;
                        if (ramp_nxt != cfg_cmpr_q) cfg_load_d = 1'b1;
                        if (pending_q) begin
                            cfg_period_d = period_sh_q;
                            cfg_load_d   = 1'b1;
                            pend_clr     = 1'b1;
                        end
                        if (ramp_nxt == eff_tgt) state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A write landing on the same edge as a consuming wrap re-arms pending.
        pending_d = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pending_q);
        busy_d    = (state_d == RAMP);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            ramp_en_q    <= 1'b0;
            pending_q    <= 1'b0;
            period_sh_q  <= '0;
            target_sh_q  <= '0;
            step_q       <= '0;
            cfg_period_q <= '0;
            cfg_cmpr_q   <= '0;
            cfg_load_q   <= 1'b0;
            pwm_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            ramp_en_q    <= ramp_en_d;
            pending_q    <= pending_d;
            period_sh_q  <= period_sh_d;
            target_sh_q  <= target_sh_d;
            step_q       <= step_d;
            cfg_period_q <= cfg_period_d;
            cfg_cmpr_q   <= cfg_cmpr_d;
            cfg_load_q   <= cfg_load_d;
            pwm_en_q     <= pwm_en_d;
            busy_q       <= busy_d;
        end
    end

    assign cfg_period = cfg_period_q;
    assign cfg_cmpr   = cfg_cmpr_q;
    assign cfg_load   = cfg_load_q;
    assign pwm_en     = pwm_en_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: APB map, START load, ramp up/down,
// target clamp, same-edge wrap/write, en drop and async reset mid-ramp.
module tb_pwm_ramp_ctrl;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic          period_wrap = 1'b0;
    logic          pwm_en, cfg_load, busy;
    logic [DW-1:0] cfg_period, cfg_cmpr;

    int checks = 0;
    int failures = 0;
    int load_cnt = 0;
    logic [DW-1:0] rdat;
    logic          rerr;

    pwm_ramp_ctrl #(.DW(DW), .AW(AW)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .period_wrap(period_wrap),
        .pwm_en(pwm_en), .cfg_period(cfg_period), .cfg_cmpr(cfg_cmpr),
        .cfg_load(cfg_load), .busy(busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (cfg_load) load_cnt <= load_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge pclk); #1;
    endtask

    task automatic apb_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wrap);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        step_clk();
        penable = 1'b1; period_wrap = wrap;
        step_clk();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; period_wrap = 1'b0;
    endtask

    task automatic apb_rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic e);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        step_clk();
        penable = 1'b1;
        #1;
        d = prdata; e = pslverr;
        step_clk();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wrap1();
        period_wrap = 1'b1;
        step_clk();
        period_wrap = 1'b0;
    endtask

    initial begin
        #12 presetn = 1'b1;
        step_clk();

        // reset state and register map
        chk("rst_pwm_en", pwm_en, 0);
        chk("rst_period", cfg_period, 0);
        chk("rst_cmpr", cfg_cmpr, 0);
        chk("rst_load", cfg_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pready", pready, 1);
        for (int a = 0; a < 6; a++) begin
            apb_rd(AW'(a), rdat, rerr);
            chk($sformatf("rst_rd%0d", a), rdat, 0);
            chk($sformatf("rst_err%0d", a), rerr, 0);
        end
        apb_rd(AW'(7), rdat, rerr);
        chk("unmapped_err", rerr, 1);
        chk("unmapped_data", rdat, 0);

        // direct start, no ramp
        apb_wr(AW'(1), 16'd100, 1'b0);
        apb_wr(AW'(2), 16'd40, 1'b0);
        apb_wr(AW'(0), 16'h1, 1'b0);
        chk("pre_start_load", cfg_load, 0);
        step_clk();
        chk("start_period", cfg_period, 100);
        chk("start_cmpr", cfg_cmpr, 40);
        chk("start_load", cfg_load, 1);
        chk("start_pwm_en", pwm_en, 1);
        step_clk();
        chk("run_load_low", cfg_load, 0);
        apb_rd(AW'(4), rdat, rerr);
        chk("run_status", rdat, 4);

        // target above period is clamped
        apb_wr(AW'(2), 16'd200, 1'b0);
        chk("clamp_hold", cfg_cmpr, 40);
        wrap1();
        chk("clamp_cmpr", cfg_cmpr, 100);
        chk("clamp_load", cfg_load, 1);

        // period write on a wrap edge waits for the following wrap
        apb_wr(AW'(1), 16'd50, 1'b1);
        chk("same_edge_period", cfg_period, 100);
        chk("same_edge_load", cfg_load, 0);
        wrap1();
        chk("next_wrap_period", cfg_period, 50);
        chk("next_wrap_cmpr", cfg_cmpr, 50);

        // en=0 from RUN
        apb_wr(AW'(0), 16'h0, 1'b0);
        step_clk();
        chk("stop_pwm_en", pwm_en, 0);
        chk("stop_cmpr", cfg_cmpr, 0);
        chk("stop_load", cfg_load, 1);
        wrap1();
        chk("idle_wrap_ign", cfg_cmpr, 0);

        // soft start ramp 0 -> 15 -> 30 -> 40
        apb_wr(AW'(1), 16'd100, 1'b0);
        apb_wr(AW'(2), 16'd40, 1'b0);
        apb_wr(AW'(3), 16'd15, 1'b0);
        apb_wr(AW'(0), 16'h3, 1'b0);
        load_cnt = 0;
        step_clk();
        chk("ramp_start_cmpr", cfg_cmpr, 0);
        chk("ramp_start_load", cfg_load, 1);
        step_clk();
        chk("ramp_busy", busy, 1);
        wrap1();
        chk("ramp_15", cfg_cmpr, 15);
        wrap1();
        chk("ramp_30", cfg_cmpr, 30);
        chk("ramp_30_busy", busy, 1);
        wrap1();
        chk("ramp_40", cfg_cmpr, 40);
        chk("ramp_done_busy", busy, 0);
        step_clk();
        chk("ramp_loads", load_cnt, 4);

        // ramp down with STEP=0 treated as 1
        apb_wr(AW'(2), 16'd10, 1'b0);
        apb_wr(AW'(3), 16'd0, 1'b0);
        chk("down_hold", cfg_cmpr, 40);
        wrap1();
        chk("down_enter", cfg_cmpr, 40);
        chk("down_busy", busy, 1);
        wrap1();
        chk("down_39", cfg_cmpr, 39);
        wrap1();
        chk("down_38", cfg_cmpr, 38);
        for (int i = 0; i < 28; i++) wrap1();
        chk("down_10", cfg_cmpr, 10);
        chk("down_done_busy", busy, 0);

        // mid-ramp en drop
        apb_wr(AW'(2), 16'd60, 1'b0);
        apb_wr(AW'(3), 16'd5, 1'b0);
        wrap1();
        wrap1();
        chk("mid_ramp_15", cfg_cmpr, 15);
        apb_wr(AW'(0), 16'h2, 1'b0);
        step_clk();
        chk("drop_pwm_en", pwm_en, 0);
        chk("drop_cmpr", cfg_cmpr, 0);
        chk("drop_busy", busy, 0);

        // async reset mid-ramp
        apb_wr(AW'(0), 16'h3, 1'b0);
        step_clk();
        step_clk();
        wrap1();
        chk("pre_rst_cmpr", cfg_cmpr, 5);
        #2 presetn = 1'b0;
        #1;
        chk("arst_cmpr", cfg_cmpr, 0);
        chk("arst_pwm_en", pwm_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_period", cfg_period, 0);
        #10 presetn = 1'b1;
        step_clk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- APB-programmable controller that configures and sequences the PWM timer datapath.
- Holds shadow copies of period and compare. Applies them to the datapath only at a period boundary, so a PWM cycle is never glitched mid-period.
- Optionally ramps the compare value toward a target duty by a fixed step each period (soft start / soft change).
- Sits between the APB bus and the PWM timer. It drives the timer's period/compare/enable and consumes the timer's end-of-period pulse.

Parameters:
- DW, 16, width of period, compare, target and step values.
- AW, 4, APB word-address width (paddr[AW-1:0]).

Ports:
- pclk  in  1  APB and timer clock; all logic rises on posedge pclk.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  AW  word address.
- pwdata  in  DW  write data.
- prdata  out  DW  read data.
- pready  out  1  tied 1, zero wait states.
- pslverr  out  1  error on unmapped address.
- period_wrap  in  1  one-cycle pulse from timer at end of each period.
- pwm_en  out  1  timer run enable.
- cfg_period  out  DW  live period to timer.
- cfg_cmpr  out  DW  live compare to timer; output high while count < cfg_cmpr.
- cfg_load  out  1  one-cycle strobe when cfg_period/cfg_cmpr change.
- busy  out  1  ramp in progress.

Behaviour:
- Reset (presetn low, asynchronous) clears all registers; all outputs 0 except pready=1. The FSM enters IDLE.
- APB access:
  - A write commits on the posedge where psel & penable & pwrite.
  - Read data is combinational: prdata is valid while psel & penable & !pwrite, else 0.
  - pslverr is 1 during the access phase for addresses > 5, else 0. Unmapped writes are ignored.
- Register map:
  - 0 CTRL: bit0 en, bit1 ramp_en.
  - 1 PERIOD shadow.
  - 2 TARGET shadow.
  - 3 STEP.
  - 4 STATUS (RO): bit0 busy, bit1 pending, bit2 state==RUN.
  - 5 CMPR (RO): live cfg_cmpr.
  - Writes to RO addresses: no effect, no error.
- A write to PERIOD or TARGET sets pending=1.
- Effective target: eff_tgt = min(TARGET, PERIOD shadow). Compare is never larger than the period.
- Effective step: STEP==0 is treated as 1.
- FSM states: IDLE, START, RUN, RAMP.
  - IDLE: pwm_en=0, cfg_cmpr=0. Goes to START the cycle after en is sampled 1.
  - START: one cycle. Loads cfg_period=PERIOD. Loads cfg_cmpr=0 if ramp_en, else eff_tgt. Pulses cfg_load, clears pending, sets pwm_en=1. Next state is RAMP if ramp_en and eff_tgt!=0, else RUN.
  - RUN: on period_wrap with pending=1, load cfg_period=PERIOD and clear pending.
    - If ramp_en: go to RAMP; cfg_cmpr is unchanged at that edge.
    - If not ramp_en: cfg_cmpr=eff_tgt.
    - In both cases pulse cfg_load.
    - period_wrap with pending=0 does nothing.
  - RAMP: busy=1. On each period_wrap, cfg_cmpr moves toward eff_tgt by the effective step.
    - Moving up: saturate at eff_tgt. Moving down: floor at eff_tgt, with no unsigned underflow.
    - Each move pulses cfg_load.
    - A pending PERIOD update is applied on the same wrap and clears pending.
    - When cfg_cmpr equals eff_tgt after the update, go to RUN.
    - A TARGET change mid-ramp retargets the ramp from the current cfg_cmpr; no restart.
- en written 0 in any state goes to IDLE on the next edge. pwm_en=0, cfg_cmpr=0, cfg_load pulses once, busy=0, pending is retained.
- Live values and cfg_load update on the same edge, so cfg_load is high exactly in the first cycle the new values are visible.
- If period_wrap and an APB write of PERIOD/TARGET occur on the same edge:
  - The wrap uses the old shadow.
  - The write sets pending for the next wrap.
- period_wrap is ignored in IDLE and START.
- Reset mid-ramp: immediate return to reset state; no partial update is visible.

Test Plan:
- Reset, read addrs 0–5 -> all 0, pslverr=0; read addr 7 -> pslverr=1, prdata=0.
- PERIOD=100, TARGET=40, en=1, ramp_en=0 -> START cycle shows cfg_period=100, cfg_cmpr=40, cfg_load=1 for one cycle, pwm_en=1; then RUN.
- PERIOD=100, TARGET=40, STEP=15, ramp_en=1, en=1 -> cfg_cmpr 0 then, on successive wraps, 15, 30, 40; busy drops on the wrap that reaches 40; 4 cfg_load pulses total.
- In RUN with cmpr=40, write TARGET=10, STEP=0, ramp_en=1 -> unchanged until wrap; then 39, 38, … to 10 on later wraps, one per wrap.
- TARGET=200 with PERIOD=100, no ramp -> cfg_cmpr=100. PERIOD write and period_wrap on the same edge -> new period appears at the following wrap, not this one.
- Mid-ramp en=0 -> next cycle pwm_en=0, cfg_cmpr=0, busy=0. Assert presetn low mid-ramp -> outputs 0 asynchronously, before the next pclk edge.
